// File: rtl/hack_mem_loader.sv
// Length-prefixed byte-stream loader that owns the Hack data RAM write port while loading.
// Optional trailer checksum enabled by defining LOADER_CHECKSUM_EN.
module hack_mem_loader #(
    parameter int unsigned ADDR_W = 14,
    parameter int unsigned WIDTH  = 16
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              start,
    input  logic              rx_valid,
    input  logic [7:0]        rx_data,
    output logic              rx_ready,
    input  logic              cpu_we,
    input  logic [ADDR_W-1:0] cpu_addr,
    input  logic [WIDTH-1:0]  cpu_d_in,
    output logic              ram_we,
    output logic [ADDR_W-1:0] ram_addr,
    output logic [WIDTH-1:0]  ram_d_in,
    output logic              cpu_hold,
    output logic              busy,
    output logic              done,
    output logic              err
);

    localparam int unsigned DEPTH = 2 ** ADDR_W;
    localparam int unsigned LEN_W = 16;

    typedef enum logic [2:0] {
        S_IDLE,
        S_LEN_HI,
        S_LEN_LO,
        S_DATA_HI,
        S_DATA_LO,
        S_WRITE,
        S_CHECK,
        S_DONE
    } state_t;

    state_t              state_q, state_nxt;
    logic [ADDR_W-1:0]   ptr_q;
    logic [LEN_W-1:0]    len_q;
    logic [WIDTH-1:0]    word_q;
    logic                err_q;
    logic                rx_ready_q;
    logic                we_q;
    logic                done_q;
    logic                busy_q;

    logic                accept_c;
    logic [LEN_W-1:0]    n_full_c;
    logic                too_long_c;
    logic                last_word_c;

`ifdef LOADER_CHECKSUM_EN
    logic [7:0]          csum_q;
`endif

    assign accept_c    = rx_valid && rx_ready_q;
    assign n_full_c    = {len_q[LEN_W-1:8], rx_data};
    assign too_long_c  = 32'(n_full_c) > DEPTH;
    assign last_word_c = 32'(ptr_q) == (32'(len_q) - 32'd1);

    // Next-state logic
    always_comb begin
        state_nxt = state_q;
        unique case (state_q)
            S_IDLE:    if (start) state_nxt = S_LEN_HI;
            S_LEN_HI:  if (accept_c) state_nxt = S_LEN_LO;
            S_LEN_LO: begin
                if (accept_c) begin
                    if (n_full_c == LEN_W'(0) || too_long_c) state_nxt = S_DONE;
                    else                                     state_nxt = S_DATA_HI;
                end
            end
            S_DATA_HI: if (accept_c) state_nxt = S_DATA_LO;
            S_DATA_LO: if (accept_c) state_nxt = S_WRITE;
            S_WRITE: begin
                if (last_word_c) begin
`ifdef LOADER_CHECKSUM_EN
                    state_nxt = S_CHECK;
`else
                    state_nxt = S_DONE;
`endif
                end else begin
                    state_nxt = S_DATA_HI;
                end
            end
`ifdef LOADER_CHECKSUM_EN
            S_CHECK:   if (accept_c) state_nxt = S_DONE;
`endif
            S_DONE:    state_nxt = S_IDLE;
            default:   state_nxt = S_IDLE;
        endcase
    end

    // State and registered status outputs, all decoded from the next state
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= S_IDLE;
            rx_ready_q <= 1'b0;
            we_q       <= 1'b0;
            done_q     <= 1'b0;
            busy_q     <= 1'b0;
        end else begin
            state_q    <= state_nxt;
            rx_ready_q <= (state_nxt == S_LEN_HI)  || (state_nxt == S_LEN_LO)  ||
                          (state_nxt == S_DATA_HI) || (state_nxt == S_DATA_LO) ||
                          (state_nxt == S_CHECK);
            we_q       <= (state_nxt == S_WRITE);
            done_q     <= (state_nxt == S_DONE);
            busy_q     <= (state_nxt != S_IDLE);
        end
    end

    // Datapath: length, word assembly, write pointer, error flag
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ptr_q  <= '0;
            len_q  <= '0;
            word_q <= '0;
            err_q  <= 1'b0;
`ifdef LOADER_CHECKSUM_EN
            csum_q <= '0;
`endif
        end else begin
            unique case (state_q)
                S_IDLE: begin
                    if (start) begin
                        ptr_q <= '0;
                        err_q <= 1'b0;
`ifdef LOADER_CHECKSUM_EN
                        csum_q <= '0;
`endif
                    end
                end
                S_LEN_HI: if (accept_c) len_q[LEN_W-1:8] <= rx_data;
                S_LEN_LO: begin
                    if (accept_c) begin
                        len_q[7:0] <= rx_data;
                        if (too_long_c) err_q <= 1'b1;
                    end
                end
                S_DATA_HI: begin
                    if (accept_c) begin
                        word_q[WIDTH-1 -: 8] <= rx_data;
`ifdef LOADER_CHECKSUM_EN
                        csum_q <= csum_q ^ rx_data;
`endif
                    end
                end
                S_DATA_LO: begin
                    if (accept_c) begin
                        word_q[7:0] <= rx_data;
`ifdef LOADER_CHECKSUM_EN
                        csum_q <= csum_q ^ rx_data;
`endif
                    end
                end
                S_WRITE: ptr_q <= ptr_q + ADDR_W'(1);
`ifdef LOADER_CHECKSUM_EN
                S_CHECK: if (accept_c && (rx_data != csum_q)) err_q <= 1'b1;
`endif
                default: ;
            endcase
        end
    end

    // RAM port: CPU pass-through in IDLE, loader registers otherwise
    assign ram_we   = (state_q == S_IDLE) ? cpu_we   : we_q;
    assign ram_addr = (state_q == S_IDLE) ? cpu_addr : ptr_q;
    assign ram_d_in = (state_q == S_IDLE) ? cpu_d_in : word_q;

    assign rx_ready = rx_ready_q;
    assign cpu_hold = busy_q;
    assign busy     = busy_q;
    assign done     = done_q;
    assign err      = err_q;

endmodule
